// File: rtl/life_pkg.sv
// ---------------------------------------------------------------------------
// life_pkg
// Shared definitions for the life board front-end sequencer:
//   - state_t   : FSM state encoding (S_IDLE .. S_RUN_WAIT)
//   - BTN_*     : bit index of each push-button in the button vectors
//   - NUM_BTN   : number of debounced buttons in this build
//   - cells()   : number of cells on an X by Y board
// Optional feature macro: LIFE_AUTORUN_EN (adds S_RUN_WAIT and the run button).
// ---------------------------------------------------------------------------
package life_pkg;

`ifdef LIFE_AUTORUN_EN
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FLIP1    = 3'd1,
    S_FLIP2    = 3'd2,
    S_STEP     = 3'd3,
    S_RUN_WAIT = 3'd4
  } state_t;

  localparam int NUM_BTN = 7;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLIP1 = 2'd1,
    S_FLIP2 = 2'd2,
    S_STEP  = 2'd3
  } state_t;

  localparam int NUM_BTN = 6;
`endif

  // Button positions; run is last so it can be dropped from the vector
  // when autorun is not built.
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_FLIP  = 4;
  localparam int BTN_STEP  = 5;
  localparam int BTN_RUN   = 6;

  function automatic int unsigned cells(input int unsigned x, input int unsigned y);
    return x * y;
  endfunction

endpackage

// File: rtl/life_debounce.sv
// ---------------------------------------------------------------------------
// life_debounce
// One push-button conditioner: 2-flop synchronizer, stability counter and
// rising-edge pulse generator. The debounced level only changes after the
// synchronized input has differed from it for 2**DEB_BITS consecutive
// samples; o_pulse is high for one cycle on each debounced 0->1 edge.
// Ports:
//   i_clk    in  1  system clock
//   i_rst_n  in  1  asynchronous active-low reset (already release-synced)
//   i_btn    in  1  raw asynchronous button, active-high
//   o_pulse  out 1  one-cycle press event
// ---------------------------------------------------------------------------
module life_debounce
  import life_pkg::*;
#(
  parameter int DEB_BITS = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic [1:0]          r_sync;
  logic [DEB_BITS-1:0] r_cnt;
  logic                r_level;
  logic                r_level_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_level_d <= r_level;
      // Any sample agreeing with the accepted level restarts the count,
      // so only an unbroken run of differing samples can flip it.
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (&r_cnt) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulse = r_level & ~r_level_d;

endmodule

// File: rtl/life_ctrl.sv
// ---------------------------------------------------------------------------
// life_ctrl
// Front-end sequencer for the life board datapath (life_1). Debounces the
// push-buttons, owns the cursor, produces the key_flip/key_flip_d edit pulse
// pair and holds key_nxt for exactly one board pass (X*Y cycles, tracked on
// life_1's cnt) per generation step. Counts completed generations.
// Optional feature macro: LIFE_AUTORUN_EN -- adds the RUN_WAIT state and a
// 2**RUN_DIV cycle timer that launches steps automatically; btn_run toggles it.
// Ports:
//   clk                    in   system clock, rising edge
//   reset                  in   asynchronous active-low reset
//   btn_up/down/left/right in   raw cursor buttons, active-high
//   btn_flip               in   raw: toggle cell under cursor
//   btn_step               in   raw: compute one generation
//   btn_run                in   raw: toggle autorun (unused without autorun)
//   cnt                    in   life_1 cell scan counter
//   cursor_x / cursor_y    out  cursor position
//   key_flip / key_flip_d  out  edit strobe and its one-cycle-delayed copy
//   key_nxt                out  high for one full pass per generation
//   busy                   out  high outside IDLE/RUN_WAIT
//   gen_count              out  completed generations, wrapping
// ---------------------------------------------------------------------------
module life_ctrl
  import life_pkg::*;
#(
  parameter int X        = 8,
  parameter int Y        = 8,
  parameter int LOG2X    = 3,
  parameter int LOG2Y    = 3,
  parameter int DEB_BITS = 16,
  parameter int GEN_BITS = 8,
  parameter int RUN_DIV  = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_flip,
  input  logic                   btn_step,
  input  logic                   btn_run,
  input  logic [LOG2X+LOG2Y-1:0] cnt,
  output logic [LOG2X-1:0]       cursor_x,
  output logic [LOG2Y-1:0]       cursor_y,
  output logic                   key_flip,
  output logic                   key_flip_d,
  output logic                   key_nxt,
  output logic                   busy,
  output logic [GEN_BITS-1:0]    gen_count
);

  localparam int                 CNT_W    = LOG2X + LOG2Y;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(cells(X, Y) - 1);
  localparam logic [LOG2X-1:0]   X_LAST   = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0]   Y_LAST   = LOG2Y'(Y - 1);

  // Reset asserts asynchronously everywhere but is released only after two
  // clean clock edges, so no flop sees a release near its clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // Button conditioning
  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_BTN-1:0] w_evt;

  assign w_btn_raw[BTN_UP]    = btn_up;
  assign w_btn_raw[BTN_DOWN]  = btn_down;
  assign w_btn_raw[BTN_LEFT]  = btn_left;
  assign w_btn_raw[BTN_RIGHT] = btn_right;
  assign w_btn_raw[BTN_FLIP]  = btn_flip;
  assign w_btn_raw[BTN_STEP]  = btn_step;
`ifdef LIFE_AUTORUN_EN
  assign w_btn_raw[BTN_RUN]   = btn_run;
`endif

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_deb
    life_debounce #(
      .DEB_BITS (DEB_BITS)
    ) u_deb (
      .i_clk   (clk),
      .i_rst_n (w_rst_n),
      .i_btn   (w_btn_raw[gi]),
      .o_pulse (w_evt[gi])
    );
  end

  logic w_up, w_down, w_left, w_right, w_flip, w_step;

  assign w_up    = w_evt[BTN_UP];
  assign w_down  = w_evt[BTN_DOWN];
  assign w_left  = w_evt[BTN_LEFT];
  assign w_right = w_evt[BTN_RIGHT];
  assign w_flip  = w_evt[BTN_FLIP];
  assign w_step  = w_evt[BTN_STEP];

  // FSM
  state_t r_state;
  state_t w_state_nxt;
  state_t w_ret_state;
  logic   w_idle_like;
  logic   w_pass_done;

  assign w_pass_done = (cnt == CNT_LAST);

`ifdef LIFE_AUTORUN_EN
  logic               w_run;
  logic               r_from_run;
  logic [RUN_DIV-1:0] r_timer;
  logic               w_timer_wrap;

  assign w_run        = w_evt[BTN_RUN];
  assign w_idle_like  = (r_state == S_IDLE) || (r_state == S_RUN_WAIT);
  assign w_ret_state  = r_from_run ? S_RUN_WAIT : S_IDLE;
  assign w_timer_wrap = &r_timer;

  // Remembers which resting state a flip/step left from, so it returns there.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_from_run <= 1'b0;
    end else if (w_idle_like) begin
      r_from_run <= (r_state == S_RUN_WAIT);
    end
  end

  // Held at zero outside RUN_WAIT, so every entry starts a full period.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_timer <= '0;
    end else if (r_state != S_RUN_WAIT) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end
`else
  logic [RUN_DIV:0] w_unused_run;

  assign w_unused_run = {btn_run, {RUN_DIV{1'b0}}};
  assign w_idle_like  = (r_state == S_IDLE);
  assign w_ret_state  = S_IDLE;
`endif

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_step) begin
          w_state_nxt = S_STEP;
        end else if (w_flip) begin
          w_state_nxt = S_FLIP1;
`ifdef LIFE_AUTORUN_EN
        end else if (w_run) begin
          w_state_nxt = S_RUN_WAIT;
`endif
        end
      end
      S_FLIP1: w_state_nxt = S_FLIP2;
      S_FLIP2: w_state_nxt = w_ret_state;
      S_STEP: begin
        if (w_pass_done) begin
          w_state_nxt = w_ret_state;
        end
      end
`ifdef LIFE_AUTORUN_EN
      S_RUN_WAIT: begin
        if (w_step) begin
          w_state_nxt = S_STEP;
        end else if (w_flip) begin
          w_state_nxt = S_FLIP1;
        end else if (w_run) begin
          w_state_nxt = S_IDLE;
        end else if (w_timer_wrap) begin
          w_state_nxt = S_STEP;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Generation counter
  logic [GEN_BITS-1:0] r_gen;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_gen <= '0;
    end else if ((r_state == S_STEP) && w_pass_done) begin
      r_gen <= r_gen + 1'b1;
    end
  end

  // Cursor: a step or flip in the same cycle takes priority over moves.
  logic [LOG2X-1:0] r_x, w_x_nxt;
  logic [LOG2Y-1:0] r_y, w_y_nxt;
  logic             w_move_en;

  assign w_move_en = w_idle_like && !w_step && !w_flip;

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (w_move_en) begin
      if (w_right && !w_left) begin
        w_x_nxt = (r_x == X_LAST) ? '0 : r_x + 1'b1;
      end else if (w_left && !w_right) begin
        w_x_nxt = (r_x == '0) ? X_LAST : r_x - 1'b1;
      end
      if (w_down && !w_up) begin
        w_y_nxt = (r_y == Y_LAST) ? '0 : r_y + 1'b1;
      end else if (w_up && !w_down) begin
        w_y_nxt = (r_y == '0) ? Y_LAST : r_y - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
    end
  end

  // Outputs
  assign cursor_x   = r_x;
  assign cursor_y   = r_y;
  assign key_flip   = (r_state == S_FLIP1);
  assign key_flip_d = (r_state == S_FLIP2);
  assign key_nxt    = (r_state == S_STEP);
  assign busy       = !w_idle_like;
  assign gen_count  = r_gen;

endmodule

// File: tb/tb_life_ctrl.sv
`timescale 1ns/1ps
module tb_life_ctrl;
  import life_pkg::*;

  localparam int X        = 8;
  localparam int Y        = 8;
  localparam int LOG2X    = 3;
  localparam int LOG2Y    = 3;
  localparam int DEB_BITS = 2;
  localparam int GEN_BITS = 8;
  localparam int RUN_DIV  = 6;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [6:0]             r_btn = '0;
  logic [LOG2X+LOG2Y-1:0] cnt;
  logic [LOG2X-1:0]       cursor_x;
  logic [LOG2Y-1:0]       cursor_y;
  logic                   key_flip, key_flip_d, key_nxt, busy;
  logic [GEN_BITS-1:0]    gen_count;

  life_ctrl #(
    .X(X), .Y(Y), .LOG2X(LOG2X), .LOG2Y(LOG2Y),
    .DEB_BITS(DEB_BITS), .GEN_BITS(GEN_BITS), .RUN_DIV(RUN_DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_up     (r_btn[BTN_UP]),
    .btn_down   (r_btn[BTN_DOWN]),
    .btn_left   (r_btn[BTN_LEFT]),
    .btn_right  (r_btn[BTN_RIGHT]),
    .btn_flip   (r_btn[BTN_FLIP]),
    .btn_step   (r_btn[BTN_STEP]),
    .btn_run    (r_btn[BTN_RUN]),
    .cnt        (cnt),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .key_flip   (key_flip),
    .key_flip_d (key_flip_d),
    .key_nxt    (key_nxt),
    .busy       (busy),
    .gen_count  (gen_count)
  );

  always #5 clk = ~clk;

  // life_1 scan counter: held at 0 unless key_nxt, otherwise walks the board.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (key_nxt) cnt <= cnt + 1'b1;
    else cnt <= '0;
  end

  // Output activity monitor, sampled on the falling edge.
  int cyc = 0;
  int n_flip = 0, n_flipd = 0, n_nxt = 0, n_busy = 0;
  int t_flip = 0, t_flipd = 0, first_cnt = -1, last_cnt = -1;

  always @(negedge clk) begin
    cyc++;
    if (key_flip)   begin n_flip++;  t_flip  = cyc; end
    if (key_flip_d) begin n_flipd++; t_flipd = cyc; end
    if (key_nxt) begin
      if (n_nxt == 0) first_cnt = int'(cnt);
      last_cnt = int'(cnt);
      n_nxt++;
    end
    if (busy) n_busy++;
  end

  task automatic clear_mon();
    n_flip = 0; n_flipd = 0; n_nxt = 0; n_busy = 0;
    t_flip = 0; t_flipd = 0; first_cnt = -1; last_cnt = -1;
  endtask

  // Checking and scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  string       sb_tag[$];
  logic [31:0] sb_val[$];

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    sb_tag.push_back(tag);
    sb_val.push_back(v);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (sb_tag.size() == 0) begin
      chk_eq("scoreboard_empty", obs, 32'hFFFF_FFFF);
    end else begin
      chk_eq(sb_tag.pop_front(), obs, sb_val.pop_front());
    end
  endtask

  // All stimulus and checks happen 2ns after the rising edge.
  int tnow = 0;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      tnow++;
    end
  endtask

  task automatic press(input logic [6:0] mask, input int hold);
    r_btn = mask;
    tick(hold);
    r_btn = '0;
    tick(12);
  endtask

  task automatic wait_nxt(input logic lvl, input int max, input string tag);
    int i;
    for (i = 0; i < max && key_nxt !== lvl; i++) tick(1);
    if (key_nxt !== lvl) chk_eq(tag, key_nxt, lvl);
  endtask

  localparam logic [6:0] M_UP    = 7'(1 << BTN_UP);
  localparam logic [6:0] M_DOWN  = 7'(1 << BTN_DOWN);
  localparam logic [6:0] M_LEFT  = 7'(1 << BTN_LEFT);
  localparam logic [6:0] M_RIGHT = 7'(1 << BTN_RIGHT);
  localparam logic [6:0] M_FLIP  = 7'(1 << BTN_FLIP);
  localparam logic [6:0] M_STEP  = 7'(1 << BTN_STEP);
  localparam logic [6:0] M_RUN   = 7'(1 << BTN_RUN);

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int mx, my, t1, t2, t3;
    mx = 0; my = 0;

    // Reset state
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(6);
    chk_eq("rst_cursor_x", cursor_x, 0);
    chk_eq("rst_cursor_y", cursor_y, 0);
    chk_eq("rst_key_flip", key_flip, 0);
    chk_eq("rst_key_flip_d", key_flip_d, 0);
    chk_eq("rst_key_nxt", key_nxt, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_gen_count", gen_count, 0);

    // Debounce and cursor wrap
    sb_push("short_hold_x", mx);
    press(M_RIGHT, 3);
    sb_pop(cursor_x);

    for (int i = 0; i < 9; i++) begin
      mx = (mx + 1) % X;
      sb_push($sformatf("right_%0d_x", i), mx);
      press(M_RIGHT, 10);
      sb_pop(cursor_x);
    end

    for (int i = 0; i < 2; i++) begin
      mx = (mx + X - 1) % X;
      sb_push($sformatf("left_%0d_x", i), mx);
      press(M_LEFT, 10);
      sb_pop(cursor_x);
    end

    sb_push("cancel_lr_x", mx);
    press(M_LEFT | M_RIGHT, 10);
    sb_pop(cursor_x);

    my = (my + Y - 1) % Y;
    sb_push("up_wrap_y", my);
    press(M_UP, 10);
    sb_pop(cursor_y);

    mx = (mx + 1) % X;
    my = (my + 1) % Y;
    sb_push("diag_x", mx);
    sb_push("diag_y", my);
    press(M_DOWN | M_RIGHT, 10);
    sb_pop(cursor_x);
    sb_pop(cursor_y);

    // Flip pulse pair
    clear_mon();
    sb_push("flip_cycles", 1);
    sb_push("flip_d_cycles", 1);
    sb_push("flip_d_lag", 1);
    sb_push("flip_busy_cycles", 2);
    press(M_FLIP, 10);
    sb_pop(n_flip);
    sb_pop(n_flipd);
    sb_pop(t_flipd - t_flip);
    sb_pop(n_busy);

    // Step: one full pass, movement during pass ignored
    clear_mon();
    sb_push("step_nxt_cycles", 64);
    sb_push("step_first_cnt", 0);
    sb_push("step_last_cnt", X * Y - 1);
    sb_push("step_busy_cycles", 64);
    sb_push("step_gen", 1);
    sb_push("step_move_ignored_x", mx);
    r_btn = M_STEP;
    tick(10);
    r_btn = '0;
    tick(2);
    r_btn = M_RIGHT;
    tick(10);
    r_btn = '0;
    tick(80);
    sb_pop(n_nxt);
    sb_pop(first_cnt);
    sb_pop(last_cnt);
    sb_pop(n_busy);
    sb_pop(gen_count);
    sb_pop(cursor_x);

    // Step and flip on the same cycle: step wins
    clear_mon();
    sb_push("both_flip_cycles", 0);
    sb_push("both_nxt_cycles", 64);
    sb_push("both_gen", 2);
    press(M_STEP | M_FLIP, 10);
    tick(80);
    sb_pop(n_flip);
    sb_pop(n_nxt);
    sb_pop(gen_count);

    // Reset in the middle of a pass
    r_btn = M_STEP;
    tick(10);
    r_btn = '0;
    for (int i = 0; i < 200 && !(key_nxt && cnt == 30); i++) tick(1);
    chk_eq("mid_pass_cnt30", (key_nxt && cnt == 30), 1);
    reset = 1'b0;
    #1;
    chk_eq("abort_key_nxt", key_nxt, 0);
    chk_eq("abort_gen", gen_count, 0);
    chk_eq("abort_busy", busy, 0);
    tick(3);
    reset = 1'b1;
    tick(6);
    mx = 0; my = 0;
    chk_eq("post_abort_gen", gen_count, 0);
    chk_eq("post_abort_x", cursor_x, mx);
    chk_eq("post_abort_nxt", key_nxt, 0);

`ifdef LIFE_AUTORUN_EN
    // Autorun: one pass every 128 cycles until run is pressed again
    press(M_RUN, 10);
    wait_nxt(1'b1, 200, "run_first_rise");
    t1 = tnow;
    wait_nxt(1'b0, 100, "run_first_fall");
    chk_eq("run_gen1", gen_count, 1);
    wait_nxt(1'b1, 200, "run_second_rise");
    t2 = tnow;
    chk_eq("run_period1", t2 - t1, 128);
    wait_nxt(1'b0, 100, "run_second_fall");
    chk_eq("run_gen2", gen_count, 2);
    wait_nxt(1'b1, 200, "run_third_rise");
    t3 = tnow;
    chk_eq("run_period2", t3 - t2, 128);
    wait_nxt(1'b0, 100, "run_third_fall");
    chk_eq("run_gen3", gen_count, 3);
    press(M_RUN, 10);
    clear_mon();
    tick(300);
    chk_eq("run_stop_nxt", n_nxt, 0);
    chk_eq("run_stop_busy", busy, 0);
    chk_eq("run_stop_gen", gen_count, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
